// File: rtl/uart_tx_fifo_reader_pkg.sv
// Shared types and constants for the UART transmit path.
// The PARITY state is present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  // 100 MHz system clock / 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_reader_if.sv
// Read-side handshake between the TX FIFO and the transmit engine.
// master = FIFO reader (pops), slave = FIFO (supplies data and empty flag).
interface uart_tx_fifo_reader_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [DATA_BITS-1:0] fifo_rd_data;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );

endinterface

// File: rtl/uart_tx_fifo_reader_baud_gen.sv
// Clocks-per-bit counter; bit_tick marks the last clock of each bit period.
// The counter is held at zero while disabled and on restart.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic bit_tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;
  logic          at_last;

  assign at_last  = (count == LAST);
  assign bit_tick = enable && !restart && at_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (restart || !enable || at_last) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// 8N1 UART transmitter that pops bytes from the TX FIFO and shifts them out LSB first.
// Optional even parity bit between data and stop bits: define UART_TX_PARITY_EN.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_enable,
  uart_tx_fifo_reader_if.master  fifo,
  output logic                   tx,
  output logic                   busy,
  output logic                   frame_done
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 2) begin : g_bad_data
      $error("DATA_BITS must be at least 2");
    end
  endgenerate

  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [IW-1:0]        bit_idx, bit_idx_next;
  logic                 tx_next;
  logic                 start_ok;
  logic                 baud_en;
  logic                 baud_restart;
  logic                 bit_tick;

`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .enable  (baud_en),
    .restart (baud_restart),
    .bit_tick(bit_tick)
  );

  assign start_ok = tx_enable && !fifo.fifo_empty;
  assign busy     = (state != IDLE);

  always_comb begin
    state_next      = state;
    shreg_next      = shreg;
    bit_idx_next    = bit_idx;
    tx_next         = tx;
    fifo.fifo_rd_en = 1'b0;
    frame_done      = 1'b0;
    baud_en         = 1'b0;
    baud_restart    = 1'b0;

    // tx is registered: tx_next is the level for the state being entered
    unique case (state)
      IDLE: begin
        tx_next = IDLE_LEVEL;
        if (start_ok) begin
          state_next = FETCH;
        end
      end

      FETCH: begin
        fifo.fifo_rd_en = !fifo.fifo_empty;
        state_next      = fifo.fifo_empty ? IDLE : LOAD;
      end

      LOAD: begin
        shreg_next   = fifo.fifo_rd_data;
        bit_idx_next = '0;
        baud_restart = 1'b1;
        tx_next      = 1'b0;
        state_next   = START;
      end

      START: begin
        baud_en = 1'b1;
        if (bit_tick) begin
          tx_next    = shreg[0];
          state_next = DATA;
        end
      end

      DATA: begin
        baud_en = 1'b1;
        if (bit_tick) begin
          if (bit_idx == LAST_DATA) begin
            bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
            tx_next      = parity;
            state_next   = PARITY;
`else
            tx_next      = IDLE_LEVEL;
            state_next   = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + IW'(1);
            shreg_next   = shreg >> 1;
            tx_next      = shreg[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        baud_en = 1'b1;
        if (bit_tick) begin
          tx_next    = IDLE_LEVEL;
          state_next = STOP;
        end
      end
`endif

      STOP: begin
        baud_en = 1'b1;
        tx_next = IDLE_LEVEL;
        if (bit_tick) begin
          if (bit_idx == LAST_STOP) begin
            frame_done   = 1'b1;
            bit_idx_next = '0;
            state_next   = start_ok ? FETCH : IDLE;
          end else begin
            bit_idx_next = bit_idx + IW'(1);
          end
        end
      end

      default: begin
        tx_next    = IDLE_LEVEL;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx      <= IDLE_LEVEL;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity <= 1'b0;
    end else if (state == LOAD) begin
      parity <= ^fifo.fifo_rd_data;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Randomised bench: a FIFO model feeds the transmitter and a frame-level
// reference predicts pops, line levels, busy and frame_done every clock.
module tb_uart_tx_fifo_reader;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DBITS = 8;
  localparam int unsigned SBITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned FRAME_LEN = (1 + DBITS + PBITS + SBITS) * CPB;

  logic clk       = 1'b0;
  logic rst       = 1'b0;
  logic tx_enable = 1'b0;
  logic tx;
  logic busy;
  logic frame_done;

  uart_tx_fifo_reader_if #(.DATA_BITS(DBITS)) fifo_bus ();

  uart_tx_fifo_reader #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DBITS),
    .STOP_BITS   (SBITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_enable (tx_enable),
    .fifo      (fifo_bus),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // FIFO model: bytes are written by the stimulus, popped on fifo_rd_en
  logic [7:0] mem [0:1023];
  int n_pushed = 0;
  int n_popped = 0;

  assign fifo_bus.fifo_empty = (n_pushed == n_popped);

  always @(posedge clk) begin
    if (fifo_bus.fifo_rd_en) begin
      fifo_bus.fifo_rd_data <= mem[n_popped];
      n_popped              <= n_popped + 1;
    end
  end

  logic rst_at_edge = 1'b0;
  always @(posedge clk) rst_at_edge <= rst;

  function automatic logic exp_bit(input int unsigned p, input logic [7:0] b);
    int unsigned k;
    k = p / CPB;
    if (k == 0) return 1'b0;
    if (k <= DBITS) return b[k-1];
    if (PBITS == 1 && k == DBITS + 1) return ^b;
    return 1'b1;
  endfunction

  // Reference: a pop is due the cycle after IDLE sees enable and data;
  // the start bit begins two clocks after the pop.
  int          cyc           = 0;
  bit          in_frame      = 1'b0;
  bit          start_pending = 1'b0;
  int          start_cyc     = 0;
  int unsigned pos           = 0;
  int          frames_done   = 0;
  logic [7:0]  cur_byte      = '0;

  initial begin : monitor
    logic last;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_at_edge) begin
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rd_en", fifo_bus.fifo_rd_en, 1'b0);
        check_eq("rst_done", frame_done, 1'b0);
        in_frame      = 1'b0;
        start_pending = 1'b0;
      end else begin
        last = 1'b0;
        if (start_pending && cyc == start_cyc) begin
          start_pending = 1'b0;
          in_frame      = 1'b1;
          pos           = 0;
          cur_byte      = mem[n_popped-1];
        end
        if (in_frame) begin
          check_eq("frame_tx", tx, exp_bit(pos, cur_byte));
          check_eq("frame_done", frame_done, pos == FRAME_LEN - 1);
          check_eq("frame_busy", busy, 1'b1);
          last = (pos == FRAME_LEN - 1);
          pos++;
          if (last) begin
            in_frame = 1'b0;
            frames_done++;
          end
        end else if (start_pending) begin
          check_eq("fetch_tx", tx, 1'b1);
          check_eq("fetch_busy", busy, 1'b1);
          check_eq("fetch_done", frame_done, 1'b0);
        end else begin
          check_eq("idle_tx", tx, 1'b1);
          check_eq("idle_busy", busy, 1'b0);
          check_eq("idle_done", frame_done, 1'b0);
        end
        check_eq("rd_en", fifo_bus.fifo_rd_en, start_pending && cyc == start_cyc - 2);
        if (fifo_bus.fifo_rd_en) check_eq("rd_en_empty", fifo_bus.fifo_empty, 1'b0);
      end
      if (!in_frame && !start_pending && tx_enable && !fifo_bus.fifo_empty && rst) begin
        start_pending = 1'b1;
        start_cyc     = cyc + 3;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[n_pushed] = b;
    n_pushed++;
  endtask

  task automatic drain(input string tag);
    int unsigned budget;
    logic        ok;
    budget = (n_pushed - n_popped + 2) * (FRAME_LEN + 4) + 20;
    ok     = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (n_pushed == n_popped && !busy && !in_frame && !start_pending) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check_eq(tag, ok, 1'b1);
  endtask

  task automatic wait_pos(input string tag, input int unsigned p);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME_LEN; i++) begin
      if (in_frame && pos == p) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check_eq(tag, ok, 1'b1);
  endtask

  int f0;
  int p0;

  initial begin
    tick(3);
    rst = 1'b1;
    tick(2);

    // single byte
    f0 = frames_done; p0 = n_popped;
    push(8'hA5);
    tx_enable = 1'b1;
    drain("drain_a5");
    check_eq("frames_a5", frames_done - f0, 1);
    check_eq("pops_a5", n_popped - p0, 1);

    // back-to-back frames
    f0 = frames_done; p0 = n_popped;
    push(8'h00);
    push(8'hFF);
    drain("drain_b2b");
    check_eq("frames_b2b", frames_done - f0, 2);
    check_eq("pops_b2b", n_popped - p0, 2);

    // empty FIFO for 100 clocks
    f0 = frames_done;
    tick(100);
    check_eq("frames_empty", frames_done - f0, 0);

    // reset mid-frame discards the byte in flight
    f0 = frames_done; p0 = n_popped;
    push(8'h3C);
    push(8'h55);
    wait_pos("wait_rst_pt", 15);
    rst = 1'b0;
    tick(3);
    check_eq("pops_in_rst", n_popped - p0, 1);
    rst = 1'b1;
    drain("drain_rst");
    check_eq("frames_rst", frames_done - f0, 1);
    check_eq("pops_rst", n_popped - p0, 2);

    // tx_enable dropped during bit 3
    f0 = frames_done; p0 = n_popped;
    push(8'h12);
    push(8'h34);
    push(8'h56);
    wait_pos("wait_bit3", 4 + 3 * CPB + 1);
    tx_enable = 1'b0;
    tick(150);
    check_eq("frames_dis", frames_done - f0, 1);
    check_eq("pops_dis", n_popped - p0, 1);
    tx_enable = 1'b1;
    drain("drain_dis");
    check_eq("frames_reen", frames_done - f0, 3);

    // parity-relevant byte
    f0 = frames_done;
    push(8'h07);
    drain("drain_07");
    check_eq("frames_07", frames_done - f0, 1);

    // random traffic with enable toggling and occasional resets
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) push(8'($urandom_range(0, 255)));
      tx_enable = ($urandom_range(0, 3) != 0);
      tick(int'($urandom_range(1, 60)));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
      end
    end
    tx_enable = 1'b1;
    drain("drain_rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
